// File: rtl/cancid_stream_ctx_v4.sv
// Per-stream context manager for one regex category engine: saves and
// restores DFA state per stream ID, gates characters to the active packet,
// tracks per-packet matches and keeps saturating per-stream/global counts.
module cancid_stream_ctx_v4 #(
    parameter int unsigned STATE_W = 11,
    parameter int unsigned SID_W   = 6,
    parameter int unsigned COUNT_W = 16,
    parameter int unsigned TOTAL_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_state,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               new_stream_id,
    input  logic               enable,
    input  logic               char_in_vld,
    input  logic               eop,
    input  logic [STATE_W-1:0] core_state_out,
    input  logic               core_accept,
    output logic [STATE_W-1:0] core_state_in,
    output logic               core_state_in_vld,
    output logic               core_char_vld,
    output logic               fired,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [COUNT_W-1:0] rd_count,
    output logic [TOTAL_W-1:0] total_count
);

    localparam int unsigned NUM_STREAMS = 2 ** SID_W;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
    localparam logic [TOTAL_W-1:0] TOTAL_MAX = {TOTAL_W{1'b1}};

    logic [0:0]         state_q;
    logic [0:0]         state_d;
    logic [SID_W-1:0]   cur_sid;
    logic               cur_en;
    logic [NUM_STREAMS-1:0] valid_q;

    // Context RAMs: not reset, staleness is tracked by valid_q.
    logic [STATE_W-1:0] state_mem [NUM_STREAMS];
    logic [COUNT_W-1:0] count_mem [NUM_STREAMS];

    logic               is_active;
    logic               end_pkt;
    logic               commit;
    logic               do_load;
    logic               do_clear;
    logic               hit;
    logic               fwd;
    logic [STATE_W-1:0] restore_val;
    logic [COUNT_W-1:0] cur_count;
    logic [COUNT_W-1:0] count_next;
    logic [TOTAL_W-1:0] total_next;

    // Event decode; reset suppresses every RAM write so a mid-packet reset discards the packet.
    always_comb begin
        is_active = (state_q == ACTIVE);
        end_pkt   = is_active & eop;
        commit    = rst_n & end_pkt & cur_en;
        do_load   = rst_n & load_state;
        do_clear  = do_load & new_stream_id;
        hit       = fired | core_accept;
        fwd       = end_pkt & cur_en & (stream_id == cur_sid);
    end

    // Restore value: a fresh stream restarts at zero, a same-cycle commit to
    // the same stream is forwarded, otherwise the saved state if still valid.
    always_comb begin
        restore_val = '0;
        if (new_stream_id) begin
            restore_val = '0;
        end else if (fwd) begin
            restore_val = core_state_out;
        end else if (valid_q[stream_id]) begin
            restore_val = state_mem[stream_id];
        end
    end

    // Saturating increments for the committing stream and the global total.
    always_comb begin
        cur_count  = count_mem[cur_sid];
        count_next = cur_count;
        total_next = total_count;
        if (hit && (cur_count != COUNT_MAX)) begin
            count_next = cur_count + COUNT_W'(1);
        end
        if (hit && (total_count != TOTAL_MAX)) begin
            total_next = total_count + TOTAL_W'(1);
        end
    end

    // FSM next state: a load always (re)enters ACTIVE, eop closes the packet.
    always_comb begin
        state_d = state_q;
        if (load_state) begin
            state_d = ACTIVE;
        end else if (end_pkt) begin
            state_d = IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-packet context: stream, enable and the speculative match flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_sid <= '0;
            cur_en  <= 1'b0;
            fired   <= 1'b0;
        end else begin
            if (load_state) begin
                cur_sid <= stream_id;
                cur_en  <= enable;
                fired   <= 1'b0;
            end else if (end_pkt && !cur_en) begin
                fired   <= 1'b0;
            end else if (is_active && core_accept) begin
                fired   <= 1'b1;
            end
        end
    end

    // One-cycle restore strobe and held restore state toward the core.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_state_in     <= '0;
            core_state_in_vld <= 1'b0;
        end else begin
            core_state_in_vld <= load_state;
            if (load_state) begin
                core_state_in <= restore_val;
            end
        end
    end

    // Global matched-packet counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_count <= '0;
        end else if (commit) begin
            total_count <= total_next;
        end
    end

    // Valid bitmap: commit marks valid, then a new-stream load clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (commit) begin
                valid_q[cur_sid] <= 1'b1;
            end
            if (do_clear) begin
                valid_q[stream_id] <= 1'b0;
            end
        end
    end

    // Context RAM writes: commit first, then the new-stream count clear wins.
    always_ff @(posedge clk) begin
        if (commit) begin
            state_mem[cur_sid] <= core_state_out;
            count_mem[cur_sid] <= count_next;
        end
        if (do_clear) begin
            count_mem[stream_id] <= '0;
        end
    end

    // Registered count read port, old data on a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_count <= '0;
        end else begin
            rd_count <= count_mem[rd_sid];
        end
    end

    // Characters reach the core only while a packet is active.
    always_comb begin
        core_char_vld = char_in_vld & is_active;
    end

endmodule

// File: tb/tb_cancid_stream_ctx_v4.sv
// Scoreboard bench for cancid_stream_ctx_v4: directed packets from the test
// plan followed by random traffic, checked against a packet-level model.
module tb_cancid_stream_ctx_v4;

    localparam int unsigned STATE_W = 11;
    localparam int unsigned SID_W   = 4;
    localparam int unsigned COUNT_W = 6;
    localparam int unsigned TOTAL_W = 9;
    localparam int NS   = 2 ** SID_W;
    localparam int CMAX = (1 << COUNT_W) - 1;
    localparam int TMAX = (1 << TOTAL_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               load_state;
    logic [SID_W-1:0]   stream_id;
    logic               new_stream_id;
    logic               enable;
    logic               char_in_vld;
    logic               eop;
    logic [STATE_W-1:0] core_state_out;
    logic               core_accept;
    logic [STATE_W-1:0] core_state_in;
    logic               core_state_in_vld;
    logic               core_char_vld;
    logic               fired;
    logic [SID_W-1:0]   rd_sid;
    logic [COUNT_W-1:0] rd_count;
    logic [TOTAL_W-1:0] total_count;

    cancid_stream_ctx_v4 #(
        .STATE_W(STATE_W), .SID_W(SID_W), .COUNT_W(COUNT_W), .TOTAL_W(TOTAL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_state(load_state), .stream_id(stream_id),
        .new_stream_id(new_stream_id), .enable(enable), .char_in_vld(char_in_vld),
        .eop(eop), .core_state_out(core_state_out), .core_accept(core_accept),
        .core_state_in(core_state_in), .core_state_in_vld(core_state_in_vld),
        .core_char_vld(core_char_vld), .fired(fired), .rd_sid(rd_sid),
        .rd_count(rd_count), .total_count(total_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               vld;
        logic [STATE_W-1:0] csi;
        logic               fired;
        logic [TOTAL_W-1:0] total;
        logic               rd_known;
        logic [COUNT_W-1:0] rd;
    } status_t;

    status_t            sq[$];
    logic [STATE_W-1:0] rq[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stream contexts and the current packet.
    int  m_state [NS];
    bit  m_valid [NS];
    int  m_count [NS];
    bit  m_known [NS];
    bit  m_active = 0;
    int  m_sid    = 0;
    bit  m_en     = 0;
    bit  m_fired  = 0;
    int  m_total  = 0;
    int  m_csi    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model applies commit-then-load semantics.
    task automatic cyc(input bit r, input bit ld, input int sid, input bit nw, input bit en,
                       input bit ch, input bit ep, input int cso, input bit ac, input int rd);
        status_t s;
        int restore;
        @(negedge clk);
        rst_n          = r;
        load_state     = ld;
        stream_id      = SID_W'(sid);
        new_stream_id  = nw;
        enable         = en;
        char_in_vld    = ch;
        eop            = ep;
        core_state_out = STATE_W'(cso);
        core_accept    = ac;
        rd_sid         = SID_W'(rd);
        #1;
        chk("char_gate", 64'(core_char_vld), 64'(ch && m_active));
        s = '0;
        if (!r) begin
            m_active = 0;
            m_fired  = 0;
            m_total  = 0;
            m_csi    = 0;
            for (int i = 0; i < NS; i++) m_valid[i] = 0;
            s.vld = 0;
        end else begin
            s.rd_known = m_known[rd];
            s.rd       = COUNT_W'(m_count[rd]);
            if (m_active && ep) begin
                if (m_en) begin
                    bit h = m_fired || ac;
                    m_state[m_sid] = cso;
                    m_valid[m_sid] = 1;
                    if (h && m_count[m_sid] < CMAX) m_count[m_sid]++;
                    if (h && m_total < TMAX) m_total++;
                    m_fired = h;
                end else begin
                    m_fired = 0;
                end
                m_active = 0;
            end else if (m_active && ac) begin
                m_fired = 1;
            end
            if (ld) begin
                restore = (nw || !m_valid[sid]) ? 0 : m_state[sid];
                if (nw) begin
                    m_count[sid] = 0;
                    m_valid[sid] = 0;
                    m_known[sid] = 1;
                end
                m_active = 1;
                m_sid    = sid;
                m_en     = en;
                m_fired  = 0;
                m_csi    = restore;
                rq.push_back(STATE_W'(restore));
            end
            s.vld = ld;
        end
        s.csi   = STATE_W'(m_csi);
        s.fired = m_fired;
        s.total = TOTAL_W'(m_total);
        sq.push_back(s);
    endtask

    task automatic idle(input int rd);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, rd);
    endtask

    // Monitor: pops expectations after each active edge and compares.
    initial begin
        status_t s;
        logic [STATE_W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("restore_vld", 64'(core_state_in_vld), 64'(s.vld));
                if (core_state_in_vld) begin
                    if (rq.size() == 0) begin
                        chk("restore_unexpected", 64'(1), 64'(0));
                    end else begin
                        e = rq.pop_front();
                        chk("restore_state", 64'(core_state_in), 64'(e));
                    end
                end
                chk("core_state_in", 64'(core_state_in), 64'(s.csi));
                chk("fired", 64'(fired), 64'(s.fired));
                chk("total_count", 64'(total_count), 64'(s.total));
                if (s.rd_known) chk("rd_count", 64'(rd_count), 64'(s.rd));
            end
        end
    end

    initial begin
        rst_n = 1'b0; load_state = 1'b0; stream_id = '0; new_stream_id = 1'b0;
        enable = 1'b0; char_in_vld = 1'b0; eop = 1'b0; core_state_out = '0;
        core_accept = 1'b0; rd_sid = '0;
        for (int i = 0; i < NS; i++) begin
            m_state[i] = 0; m_valid[i] = 0; m_count[i] = 0; m_known[i] = 0;
        end

        // Reset
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Give every stream a defined count via new-stream loads.
        for (int s = 0; s < NS; s++) cyc(1, 1, s, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(0);

        // New stream 5, accept mid-packet, commit 0x2A5.
        cyc(1, 1, 5, 1, 1, 0, 0, 0, 0, 5);
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 5);
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 1, 5);
        cyc(1, 0, 0, 0, 0, 1, 1, 'h2A5, 0, 5);
        idle(5);

        // Reload stream 5, no accept.
        cyc(1, 1, 5, 0, 1, 0, 0, 0, 0, 5);
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 5);
        cyc(1, 0, 0, 0, 0, 1, 1, 'h111, 0, 5);
        idle(5);

        // Disabled packet with accept on the eop cycle.
        cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 5);
        cyc(1, 0, 0, 0, 0, 1, 1, 'h3FF, 1, 5);
        idle(5);
        cyc(1, 1, 5, 0, 1, 0, 0, 0, 0, 5);
        cyc(1, 0, 0, 0, 0, 0, 1, 'h111, 0, 5);

        // Back-to-back eop+load on stream 9 forwards 0x13.
        cyc(1, 1, 9, 1, 1, 0, 0, 0, 0, 9);
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 1, 9);
        cyc(1, 1, 9, 0, 1, 0, 1, 'h13, 0, 9);
        cyc(1, 0, 0, 0, 0, 0, 1, 'h14, 0, 9);
        idle(9);

        // Saturate count[3] and the global total with one-cycle hit packets.
        cyc(1, 1, 3, 1, 1, 0, 0, 0, 0, 3);
        for (int i = 0; i < TMAX + 8; i++) cyc(1, 1, 3, 0, 1, 0, 1, i, 1, 3);
        cyc(1, 0, 0, 0, 0, 0, 1, 'h7, 1, 3);
        idle(3);
        idle(3);

        // Reset mid-packet discards the commit and invalidates stream 9.
        cyc(1, 1, 9, 0, 1, 0, 0, 0, 0, 9);
        cyc(0, 0, 0, 0, 0, 0, 1, 'h55, 1, 9);
        cyc(1, 1, 9, 0, 1, 0, 0, 0, 0, 9);
        cyc(1, 0, 0, 0, 0, 0, 1, 'h66, 1, 9);
        idle(9);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 599) != 0),
                ($urandom_range(0, 4) == 0),
                int'($urandom_range(0, NS - 1)),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 1) == 0),
                ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, (1 << STATE_W) - 1)),
                ($urandom_range(0, 6) == 0),
                int'($urandom_range(0, NS - 1)));
        end
        idle(0);
        idle(0);
        @(posedge clk);
        #3;
        chk("restore_queue_drained", 64'(rq.size()), 64'(0));
        chk("status_queue_drained", 64'(sq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
